// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Consumer end of the ALU reservation-station issue interface. Each valid
//   issue packet reads two operands (PRF or a bypass of the previous result),
//   executes one ALU op, and one cycle later drives a wakeup/writeback strobe
//   and pushes a {inst_num, result} completion record into a small FIFO
//   toward the ROB.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   issue_pkt[126:0]           issue packet from the RS
//   exception_sig, mret_sig    flush (clears everything except cq_overflow)
//   prf_raddr1/2, prf_rdata1/2 combinational PRF read port
//   ALU_result_valid/dest/data wakeup broadcast + PRF write data
//   prf_we                     PRF write enable (suppressed for Rd==0)
//   cq_valid/ready/inst_num/result  completion FIFO head, ready/valid pop
//   cq_overflow                sticky: a completion was dropped on a full FIFO

// Operand selection for one source: tag 0 is hard zero, otherwise a match
// on the result currently on the broadcast bus beats the (stale) PRF read.
module alu_opnd_fetch (
  input  logic [7:0]  tag,
  input  logic [31:0] prf_data,
  input  logic        byp_vld,
  input  logic [7:0]  byp_dest,
  input  logic [31:0] byp_data,
  output logic [31:0] value
);
  always_comb begin
    if (tag == 8'd0)                       value = '0;
    else if (byp_vld && byp_dest == tag)   value = byp_data;
    else                                   value = prf_data;
  end
endmodule

module alu_exec_unit #(
  parameter int CQ_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [126:0] issue_pkt,
  input  logic         exception_sig,
  input  logic         mret_sig,
  output logic [7:0]   prf_raddr1,
  output logic [7:0]   prf_raddr2,
  input  logic [31:0]  prf_rdata1,
  input  logic [31:0]  prf_rdata2,
  output logic         ALU_result_valid,
  output logic [7:0]   ALU_result_dest,
  output logic [31:0]  ALU_result_data,
  output logic         prf_we,
  output logic         cq_valid,
  input  logic         cq_ready,
  output logic [31:0]  cq_inst_num,
  output logic [31:0]  cq_result,
  output logic         cq_overflow
);
  localparam int PW = $clog2(CQ_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [7:0]  op2_tag;
    logic [7:0]  op1_tag;
    logic [31:0] inst_num;
    logic        valid;
    logic [31:0] pc;
    logic [7:0]  rd;
    logic [3:0]  aluop;
    logic        alu_src1;
    logic        alu_src2;
    logic [31:0] imm;
  } issue_t;

  typedef struct packed {
    logic [31:0] inst_num;
    logic [31:0] result;
  } cq_rec_t;

  issue_t pkt;
  logic   flush;

  assign pkt   = issue_t'(issue_pkt);
  assign flush = exception_sig | mret_sig;

  assign prf_raddr1 = pkt.op1_tag;
  assign prf_raddr2 = pkt.op2_tag;

  // ---- operand fetch, one instance per source ----
  logic [1:0][7:0]  src_tag;
  logic [1:0][31:0] src_prf;
  logic [1:0][31:0] src_val;

  assign src_tag = {pkt.op2_tag, pkt.op1_tag};
  assign src_prf = {prf_rdata2, prf_rdata1};

  for (genvar s = 0; s < 2; s++) begin : g_fetch
    alu_opnd_fetch u_fetch (
      .tag      (src_tag[s]),
      .prf_data (src_prf[s]),
      .byp_vld  (ALU_result_valid),
      .byp_dest (ALU_result_dest),
      .byp_data (ALU_result_data),
      .value    (src_val[s])
    );
  end

  // ---- execute ----
  logic [31:0] op_a, op_b, alu_res;
  logic [4:0]  shamt;

  assign op_a  = pkt.alu_src1 ? pkt.pc  : src_val[0];
  assign op_b  = pkt.alu_src2 ? pkt.imm : src_val[1];
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (pkt.aluop)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a << shamt;
      4'd3:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd4:  alu_res = {31'd0, op_a < op_b};
      4'd5:  alu_res = op_a ^ op_b;
      4'd6:  alu_res = op_a >> shamt;
      4'd7:  alu_res = 32'($signed(op_a) >>> shamt);
      4'd8:  alu_res = op_a | op_b;
      4'd9:  alu_res = op_a & op_b;
      4'd10: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // ---- result / wakeup register ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ALU_result_valid <= 1'b0;
      ALU_result_dest  <= '0;
      ALU_result_data  <= '0;
      prf_we           <= 1'b0;
    end else begin
      ALU_result_valid <= pkt.valid;
      // Rd==0 still wakes up (harmless: nothing waits on tag 0) but never writes
      prf_we           <= pkt.valid && (pkt.rd != 8'd0);
      if (pkt.valid) begin
        ALU_result_dest <= pkt.rd;
        ALU_result_data <= alu_res;
      end
    end
  end

  // ---- completion queue ----
  cq_rec_t        cq_mem [CQ_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cq_cnt;
  logic           cq_full, cq_pop, cq_push_ok;

  assign cq_valid    = (cq_cnt != '0);
  assign cq_full     = (cq_cnt == CW'(CQ_DEPTH));
  assign cq_pop      = cq_valid && cq_ready;
  // a pop in the same cycle frees the slot even when full
  assign cq_push_ok  = pkt.valid && (!cq_full || cq_pop);
  assign cq_inst_num = cq_mem[rd_ptr].inst_num;
  assign cq_result   = cq_mem[rd_ptr].result;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cq_cnt <= '0;
      for (int i = 0; i < CQ_DEPTH; i++) cq_mem[i] <= '0;
    end else begin
      if (cq_push_ok) begin
        cq_mem[wr_ptr] <= '{inst_num: pkt.inst_num, result: alu_res};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (cq_pop) rd_ptr <= rd_ptr + PW'(1);
      cq_cnt <= cq_cnt + CW'(cq_push_ok) - CW'(cq_pop);
    end
  end

  // overflow survives a flush; only reset clears it
  always_ff @(posedge clk) begin
    if (reset)
      cq_overflow <= 1'b0;
    else if (!flush && pkt.valid && cq_full && !cq_pop)
      cq_overflow <= 1'b1;
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [126:0] issue_pkt;
  logic         exception_sig, mret_sig;
  logic [7:0]   prf_raddr1, prf_raddr2;
  logic [31:0]  prf_rdata1, prf_rdata2;
  logic         ALU_result_valid;
  logic [7:0]   ALU_result_dest;
  logic [31:0]  ALU_result_data;
  logic         prf_we;
  logic         cq_valid, cq_ready;
  logic [31:0]  cq_inst_num, cq_result;
  logic         cq_overflow;

  always #5 clk = ~clk;

  // bench-owned register file; never written by the DUT so bypass is observable
  logic [31:0] prf_mem [256];
  assign prf_rdata1 = prf_mem[prf_raddr1];
  assign prf_rdata2 = prf_mem[prf_raddr2];

  alu_exec_unit #(.CQ_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .issue_pkt(issue_pkt),
    .exception_sig(exception_sig), .mret_sig(mret_sig),
    .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
    .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
    .ALU_result_valid(ALU_result_valid), .ALU_result_dest(ALU_result_dest),
    .ALU_result_data(ALU_result_data), .prf_we(prf_we),
    .cq_valid(cq_valid), .cq_ready(cq_ready),
    .cq_inst_num(cq_inst_num), .cq_result(cq_result),
    .cq_overflow(cq_overflow)
  );

  // ---- reference model state ----
  logic        m_vld, m_we, m_ovf;
  logic [7:0]  m_dest;
  logic [31:0] m_data;
  logic [63:0] m_q [$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return 32'($signed(a) >>> sh);
      8: return a | b;
      9: return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] opnd(input logic [7:0] t);
    if (t == 0) return 32'd0;
    if (m_vld && m_dest == t) return m_data;
    return prf_mem[t];
  endfunction

  function automatic logic [126:0] mk_pkt(
      input logic [7:0] op2t, input logic [7:0] op1t, input logic [31:0] inst,
      input logic vld, input logic [31:0] pc, input logic [7:0] rd,
      input logic [3:0] op, input logic s1, input logic s2, input logic [31:0] imm);
    return {op2t, op1t, inst, vld, pc, rd, op, s1, s2, imm};
  endfunction

  // one clock: predict from current inputs, clock, then compare everything
  task automatic step();
    logic        nv, nwe, novf, pop;
    logic [7:0]  nd;
    logic [31:0] ndata, a, b, pc, imm, inst;
    logic [7:0]  t1, t2, rd;
    logic [3:0]  op;
    logic        s1, s2, pv;
    logic [63:0] nq [$];
    {t2, t1, inst, pv, pc, rd, op, s1, s2, imm} = issue_pkt;
    #1;
    check("raddr1", prf_raddr1, t1);
    check("raddr2", prf_raddr2, t2);
    nd = m_dest; ndata = m_data; novf = m_ovf; nq = m_q;
    if (reset) begin
      nv = 0; nwe = 0; nd = 0; ndata = 0; novf = 0; nq.delete();
    end else if (exception_sig || mret_sig) begin
      nv = 0; nwe = 0; nd = 0; ndata = 0; nq.delete();
    end else begin
      pop = (m_q.size() != 0) && cq_ready;
      nv = pv; nwe = pv && (rd != 0);
      if (pop) void'(nq.pop_front());
      if (pv) begin
        a = s1 ? pc  : opnd(t1);
        b = s2 ? imm : opnd(t2);
        nd = rd; ndata = alu_ref(op, a, b);
        if (nq.size() < D) nq.push_back({inst, ndata});
        else novf = 1;
      end
    end
    @(posedge clk);
    #1;
    m_vld = nv; m_we = nwe; m_dest = nd; m_data = ndata; m_ovf = novf; m_q = nq;
    check("res_valid", ALU_result_valid, m_vld);
    check("prf_we", prf_we, m_we);
    if (m_vld) begin
      check("res_dest", ALU_result_dest, m_dest);
      check("res_data", ALU_result_data, m_data);
    end
    check("cq_valid", cq_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("cq_inst", cq_inst_num, m_q[0][63:32]);
      check("cq_result", cq_result, m_q[0][31:0]);
    end
    check("cq_overflow", cq_overflow, m_ovf);
  endtask

  task automatic issue(input logic [7:0] op2t, input logic [7:0] op1t, input logic [31:0] inst,
                       input logic [31:0] pc, input logic [7:0] rd, input logic [3:0] op,
                       input logic s1, input logic s2, input logic [31:0] imm);
    issue_pkt = mk_pkt(op2t, op1t, inst, 1'b1, pc, rd, op, s1, s2, imm);
    step();
  endtask

  task automatic idle();
    issue_pkt = mk_pkt(0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic do_reset();
    reset = 1; idle(); reset = 0;
  endtask

  initial begin
    m_vld = 0; m_we = 0; m_ovf = 0; m_dest = 0; m_data = 0;
    for (int i = 0; i < 256; i++) prf_mem[i] = $urandom;
    reset = 1; exception_sig = 0; mret_sig = 0; cq_ready = 1;
    issue_pkt = '0;
    step();
    step();
    reset = 0;
    check("rst_head_inst", cq_inst_num, 0);
    check("rst_head_res", cq_result, 0);
    check("rst_dest", ALU_result_dest, 0);
    check("rst_data", ALU_result_data, 0);

    // ADD via PRF
    prf_mem[5] = 7; prf_mem[6] = 9;
    cq_ready = 0;
    issue(6, 5, 3, 0, 12, 0, 0, 0, 0);
    check("lit_add_data", ALU_result_data, 16);
    check("lit_add_dest", ALU_result_dest, 12);
    check("lit_add_we", prf_we, 1);
    check("lit_add_cq", {cq_inst_num, cq_result}, {32'd3, 32'd16});
    check("model_add", m_data, 16);
    cq_ready = 1;

    // bypass: second op reads tag 20 whose PRF copy is stale
    prf_mem[20] = 0;
    issue(0, 0, 4, 0, 20, 0, 0, 1, 100);
    issue(0, 20, 5, 0, 21, 1, 0, 1, 1);
    check("lit_bypass", ALU_result_data, 99);
    check("model_bypass", m_data, 99);

    // ops and widths
    prf_mem[1] = 32'h8000_0000; prf_mem[2] = 32'hFFFF_FFFF;
    issue(0, 1, 6, 0, 3, 7, 0, 1, 4);
    check("lit_sra", ALU_result_data, 32'hF800_0000);
    issue(0, 2, 7, 0, 3, 3, 0, 1, 1);
    check("lit_slt", ALU_result_data, 1);
    issue(0, 2, 8, 0, 3, 4, 0, 1, 1);
    check("lit_sltu", ALU_result_data, 0);
    issue(0, 2, 9, 0, 3, 0, 0, 1, 1);
    check("lit_add_wrap", ALU_result_data, 0);
    issue(0, 0, 10, 32'h1000, 4, 0, 1, 1, 4);
    check("lit_pc_add", ALU_result_data, 32'h1004);
    issue(0, 0, 11, 0, 0, 10, 0, 1, 55);
    check("lit_rd0_we", prf_we, 0);
    check("lit_rd0_vld", ALU_result_valid, 1);
    for (int i = 0; i < 4; i++) idle();

    // fill past capacity with no pops
    do_reset();
    cq_ready = 0;
    for (int i = 0; i < 5; i++) issue(0, 0, 100 + i, 0, 8, 10, 0, 1, 200 + i);
    check("lit_ovf", cq_overflow, 1);
    check("lit_head", cq_inst_num, 100);
    check("model_qsize", m_q.size(), D);
    cq_ready = 1;
    for (int i = 0; i < 5; i++) idle();
    check("lit_drained", cq_valid, 0);

    // flush with 3 queued records and a packet in the same cycle
    cq_ready = 0;
    for (int i = 0; i < 3; i++) issue(0, 0, 300 + i, 0, 9, 10, 0, 1, i);
    mret_sig = 1;
    issue(0, 0, 400, 0, 9, 10, 0, 1, 7);
    mret_sig = 0;
    check("lit_flush_cq", cq_valid, 0);
    check("lit_flush_vld", ALU_result_valid, 0);
    check("lit_flush_ovf", cq_overflow, 1);

    // full queue with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) issue(0, 0, 500 + i, 0, 10, 10, 0, 1, i);
    cq_ready = 1;
    issue(0, 0, 504, 0, 10, 10, 0, 1, 4);
    check("lit_full_pp_ovf", cq_overflow, 0);
    check("lit_full_pp_head", cq_inst_num, 501);
    check("model_full_pp_size", m_q.size(), D);
    for (int i = 0; i < 5; i++) idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] imm;
      prf_mem[$urandom_range(1, 7)] = $urandom;
      reset         = ($urandom_range(0, 199) == 0);
      exception_sig = ($urandom_range(0, 79) == 0);
      mret_sig      = ($urandom_range(0, 79) == 0);
      cq_ready      = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0: imm = $urandom_range(0, 40);
        1: imm = 32'hFFFF_FFFF;
        2: imm = 32'h8000_0000;
        default: imm = $urandom;
      endcase
      issue_pkt = mk_pkt($urandom_range(0, 7), $urandom_range(0, 7), $urandom,
                         ($urandom_range(0, 9) < 8), $urandom, $urandom_range(0, 7),
                         4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), imm);
      step();
    end
    reset = 0; exception_sig = 0; mret_sig = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Consumer end of the ALU reservation-station issue interface. Takes the 127-bit issue packet each cycle and reads both source operands from the physical register file (PRF), with a bypass from its own previous result. It computes the ALU operation and registers the result. It then broadcasts the wakeup tag back to all reservation stations, writes the PRF, and queues a completion record {inst_num, result} toward the ROB through a ready/valid FIFO.

Parameters:
CQ_DEPTH, 4, completion-queue entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset; clock clk
issue_pkt  in  127  issue packet, fields below
exception_sig  in  1  flush
mret_sig  in  1  flush
prf_raddr1  out  8  PRF read tag 1 = issue_pkt[118:111], combinational
prf_raddr2  out  8  PRF read tag 2 = issue_pkt[126:119], combinational
prf_rdata1  in  32  PRF read data 1, same cycle
prf_rdata2  in  32  PRF read data 2, same cycle
ALU_result_valid  out  1  wakeup/writeback strobe
ALU_result_dest  out  8  destination physical tag
ALU_result_data  out  32  result value; also the PRF write data
prf_we  out  1  PRF write enable
cq_valid  out  1  completion record available
cq_ready  in  1  ROB accepts record
cq_inst_num  out  32  instruction number of head record
cq_result  out  32  result of head record
cq_overflow  out  1  sticky: a completion was dropped

Behaviour:
- Packet fields: [126:119] op2 tag, [118:111] op1 tag, [110:79] inst_num, [78] valid, [77:46] PC, [45:38] Rd, [37:34] ALUOP, [33] ALUSrc1, [32] ALUSrc2, [31:0] imm.
- Packets with valid=0 are ignored. No backpressure to the RS: a valid packet is accepted every cycle.
- Operand fetch for an operand tag T:
  - T==0 gives 0.
  - Otherwise, if ALU_result_valid=1 and ALU_result_dest==T, use ALU_result_data (bypass).
  - Otherwise use prf_rdata.
- A = ALUSrc1 ? PC : op1value. B = ALUSrc2 ? imm : op2value.
- ALUOP encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (B), 11-15 result 0.
  - Shifts use B[4:0]. All arithmetic is 32-bit with wrap-around; no overflow flag.
- Latency: a valid packet in cycle N produces outputs registered in cycle N+1:
  - ALU_result_valid=1, ALU_result_dest=Rd, ALU_result_data=result.
  - prf_we=ALU_result_valid && dest!=0.
  - Rd==0 still asserts ALU_result_valid (no RS matches tag 0 as pending), but prf_we=0.
  - Outputs are held for exactly one cycle; a new packet in cycle N+1 overwrites them in N+2. Back-to-back throughput is 1/cycle.
- Completion queue (FIFO, CQ_DEPTH entries):
  - Push {inst_num, result} in the cycle the result register loads.
  - Pop when cq_valid && cq_ready. cq_valid = not empty. Head fields are driven from registered storage.
  - Push and pop in the same cycle are both allowed, including when full: the pop frees the slot and the push succeeds.
  - Full with no pop: the push is dropped and cq_overflow is set to 1 (sticky until reset).
  - Pointers wrap modulo CQ_DEPTH. The count is held in log2(CQ_DEPTH)+1 bits.
- Flush (exception_sig|mret_sig, sampled at the clock edge) behaves exactly as reset, except that cq_overflow is preserved:
  - result registers cleared, FIFO emptied, packet in the same cycle discarded.
  - Flush and a pop in the same cycle: the flush wins.
- Reset values: ALU_result_valid=0, ALU_result_dest=0, ALU_result_data=0, prf_we=0, cq_valid=0, cq_inst_num=0, cq_result=0, cq_overflow=0. Reset asserted mid-stream aborts everything.

Test Plan:
- ADD: op1 tag 5 = 7, op2 tag 6 = 9, ALUOP=0, Rd=12, inst 3 -> next cycle ALU_result_valid=1, dest 12, data 16, prf_we=1; cq holds {3,16}.
- Bypass: cycle N ADD to Rd=20 giving 100; cycle N+1 SUB with op1 tag 20 (PRF returns stale 0), imm 1, ALUSrc2=1 -> data 99.
- Ops/widths: SRA of 0x80000000 by 4 = 0xF8000000; SLT(-1,1)=1; SLTU(-1,1)=0; ADD 0xFFFFFFFF+1=0; ALUSrc1=1 PASSB/ADD uses PC; Rd=0 -> prf_we=0.
- FIFO: cq_ready=0, 5 valid packets with CQ_DEPTH=4 -> 4 queued, cq_overflow=1; raise cq_ready -> records popped in issue order, one per cycle, then cq_valid=0.
- Full + simultaneous push/pop: queue full, cq_ready=1, new packet -> no overflow, count stays 4.
- Flush: queue holding 3 records, assert mret_sig with a valid packet in the same cycle -> next cycle cq_valid=0, ALU_result_valid=0, cq_overflow unchanged.
